// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: two-digit scrolling window over a small hex-digit message buffer.
module hex_scroll_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [3:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    output logic [3:0]               digit_hi,
    output logic [3:0]               digit_lo,
    output logic                     blank_hi,
    output logic                     blank_lo,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

    state_t         state, state_nxt;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  pos, pos_inc;
    logic [TW-1:0]  tick;
    logic [CW-1:0]  count_nxt;
    logic           wr_acc, go, run, wrap;

    assign busy      = state != IDLE;
    assign wr_ready  = !busy && count < CW'(DEPTH);
    assign wr_acc    = wr_en && wr_ready && !clear;
    assign count_nxt = (!busy && clear) ? '0 : count + CW'(wr_acc);
    // start sees the post-write count so a digit written alongside start is shown
    assign go        = !busy && start && !stop && count_nxt != '0;
    assign run       = busy && !stop && !pause;
    assign wrap      = tick == TW'(TICK_DIV - 1);
    assign pos_inc   = ({1'b0, pos} == count - CW'(1)) ? '0 : pos + AW'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = busy ? (stop ? IDLE : pause ? HOLD : SCROLL) : (go ? SCROLL : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count <= '0;
            pos   <= '0;
            tick  <= '0;
        end else begin
            count <= count_nxt;
            if (go || (busy && stop)) begin
                pos  <= '0;
                tick <= '0;
            end else if (run) begin
                tick <= wrap ? '0 : tick + TW'(1);
                if (wrap) pos <= pos_inc;
            end
        end

    always_ff @(posedge clk)
        if (wr_acc) mem[count[AW-1:0]] <= wr_data;

    always_comb begin
        blank_hi = !busy && count == '0;
        blank_lo = !busy && count < CW'(2);
        digit_hi = blank_hi ? 4'h0 : mem[busy ? pos : '0];
        digit_lo = blank_lo ? 4'h0 : mem[busy ? pos_inc : AW'(1)];
    end
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb_hex_scroll_ctrl: directed + random stimulus against a message/window reference model.
module tb_hex_scroll_ctrl;
    localparam int TD = 4;
    localparam int D  = 8;

    logic       clk = 0, rst_n = 0;
    logic       wr_en = 0, clear = 0, start = 0, stop = 0, pause = 0;
    logic [3:0] wr_data = 0;
    logic       wr_ready, blank_hi, blank_lo, busy;
    logic [3:0] digit_hi, digit_lo;
    logic [3:0] count;

    int checks = 0, failures = 0;

    hex_scroll_ctrl #(.TICK_DIV(TD), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .clear(clear), .start(start), .stop(stop), .pause(pause),
        .digit_hi(digit_hi), .digit_lo(digit_lo), .blank_hi(blank_hi), .blank_lo(blank_lo),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // reference: message as an array, window position and elapsed cycles in the current step
    int m_msg [D];
    int m_cnt = 0, m_pos = 0, m_el = 0;
    bit m_run = 0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_cnt = 0; m_pos = 0; m_el = 0; m_run = 0;
        end else if (!m_run) begin
            if (clear) m_cnt = 0;
            else if (wr_en && m_cnt < D) begin
                m_msg[m_cnt] = int'(wr_data);
                m_cnt++;
            end
            if (start && !stop && m_cnt > 0) begin
                m_run = 1; m_pos = 0; m_el = 0;
            end
        end else if (stop) begin
            m_run = 0; m_pos = 0; m_el = 0;
        end else if (!pause) begin
            m_el++;
            if (m_el == TD) begin
                m_el = 0;
                m_pos = (m_pos + 1) % m_cnt;
            end
        end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        int eh, el, bh, bl;
        bh = !m_run && m_cnt == 0;
        bl = !m_run && m_cnt < 2;
        eh = bh ? 0 : m_run ? m_msg[m_pos] : m_msg[0];
        el = bl ? 0 : m_run ? m_msg[(m_pos + 1) % m_cnt] : m_msg[1];
        chk("blank_hi", int'(blank_hi), bh);
        chk("blank_lo", int'(blank_lo), bl);
        chk("digit_hi", int'(digit_hi), eh);
        chk("digit_lo", int'(digit_lo), el);
        chk("busy", int'(busy), int'(m_run));
        chk("count", int'(count), m_cnt);
        chk("wr_ready", int'(wr_ready), int'(!m_run && m_cnt < D));
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int d);
        wr_en = 1; wr_data = 4'(d);
        nxt();
        wr_en = 0;
    endtask

    task automatic pulse_start();
        start = 1; nxt(); start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; nxt(); stop = 0;
    endtask

    task automatic win(input string n, input int h, input int l);
        chk({n, "_hi"}, int'(digit_hi), h);
        chk({n, "_lo"}, int'(digit_lo), l);
    endtask

    initial begin
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_blank", int'({blank_hi, blank_lo}), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_digits", int'({digit_hi, digit_lo}), 0);
        nxt(); rst_n = 1; nxt();

        for (int i = 1; i <= 9; i++) wr(i);
        chk("fill_count", int'(count), 8);
        chk("fill_ready", int'(wr_ready), 0);
        win("fill", 1, 2);

        clear = 1; wr_en = 1; wr_data = 4'h5; nxt(); clear = 0; wr_en = 0;
        chk("clr_wr_count", int'(count), 0);

        wr(3); wr(10); wr(5);
        pulse_start();
        chk("scr_busy", int'(busy), 1);
        win("scr0", 3, 10);
        repeat (3) nxt();
        win("scr0b", 3, 10);
        nxt();   win("scr1", 10, 5);
        repeat (3) nxt();
        win("scr1b", 10, 5);
        nxt();   win("scr2", 5, 3);
        repeat (4) nxt();
        win("scr3", 3, 10);

        nxt(); nxt();
        pause = 1; wr_en = 1; wr_data = 4'hE;
        repeat (3) nxt();
        pause = 0; wr_en = 0;
        chk("hold_count", int'(count), 3);
        win("hold", 3, 10);
        nxt();   win("hold_late", 3, 10);
        nxt();   win("hold_step", 10, 5);

        start = 1; stop = 1; nxt(); start = 0; stop = 0;
        chk("ss_busy", int'(busy), 0);

        clear = 1; nxt(); clear = 0;
        pulse_start();
        chk("empty_start", int'(busy), 0);

        wr(7);
        pulse_start();
        chk("one_busy", int'(busy), 1);
        repeat (9) nxt();
        win("one", 7, 7);
        pulse_stop();

        clear = 1; nxt(); clear = 0;
        wr_en = 1; wr_data = 4'h9; start = 1; nxt(); wr_en = 0; start = 0;
        chk("wrstart_busy", int'(busy), 1);
        win("wrstart", 9, 9);
        pulse_stop();

        wr(2); wr(4);
        pulse_start();
        repeat (5) nxt();
        #1 rst_n = 0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_blank", int'({blank_hi, blank_lo}), 3);
        chk("arst_ready", int'(wr_ready), 1);
        nxt(); rst_n = 1; nxt();

        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom % 3) == 0;
            wr_data = 4'($urandom);
            clear   = ($urandom % 40) == 0;
            start   = ($urandom % 12) == 0;
            stop    = ($urandom % 40) == 0;
            if (($urandom % 8) == 0) pause = ~pause;
            nxt();
        end
        {wr_en, clear, start, stop, pause} = '0;
        nxt(); nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Sequencing controller for the two-digit 7-segment display path. It holds a short message of 4-bit hex digits loaded through a write handshake. It scrolls a two-digit window across that message at a programmable tick rate. Its digit and blank outputs drive the existing per-digit 4-bit-to-7-segment decoders feeding HEX1 (high digit) and HEX0 (low digit).

## Interface
Parameters:
- TICK_DIV, default 50000000: clock cycles per scroll step; 1 s at 50 MHz; must be ≥ 2.
- DEPTH, default 8: message buffer capacity in digits; power of 2, 2..16.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  reset; asynchronous, active-low.
- wr_en  in  1  push wr_data into the buffer; accepted only when wr_ready=1.
- wr_data  in  4  hex digit to append.
- wr_ready  out  1  high in IDLE when count < DEPTH.
- clear  in  1  single-cycle pulse; empties the buffer; honoured in IDLE only.
- start  in  1  single-cycle pulse; begins scrolling.
- stop  in  1  single-cycle pulse; ends scrolling and returns to IDLE.
- pause  in  1  level; freezes scrolling while high.
- digit_hi  out  4  code for the HEX1 decoder.
- digit_lo  out  4  code for the HEX0 decoder.
- blank_hi  out  1  1 = HEX1 must be blanked.
- blank_lo  out  1  1 = HEX0 must be blanked.
- busy  out  1  high in SCROLL or HOLD.
- count  out  $clog2(DEPTH)+1  number of stored digits, 0..DEPTH.

## Operation
- Storage:
  - DEPTH x 4-bit buffer.
  - Write index equals count.
  - Window position pos ranges 0..count-1.
  - Tick counter tick ranges 0..TICK_DIV-1.
- States:
  - IDLE: accepts writes and clear.
  - SCROLL: tick runs; pos advances.
  - HOLD: tick and pos frozen.
- Transitions:
  - IDLE -> SCROLL: start=1 and post-write count ≥ 1; pos and tick load 0. With count=0, start is ignored.
  - SCROLL -> HOLD: pause=1.
  - HOLD -> SCROLL: pause=0; tick resumes from its held value.
  - SCROLL/HOLD -> IDLE: stop=1; pos and tick load 0.
- Step rule:
  - In SCROLL, when tick = TICK_DIV-1, tick wraps to 0.
  - On that wrap, pos becomes (pos+1) mod count, i.e. pos=count-1 wraps to 0.
- Write rule:
  - If wr_en=1 and wr_ready=1: buf[count] <= wr_data and count increments.
  - Otherwise wr_en is ignored, including in SCROLL/HOLD and when full.
- Clear rule:
  - In IDLE, clear sets count to 0; buffer contents need not be zeroed.
  - If clear and wr_en occur in the same cycle, clear wins and the write is dropped.
  - clear is ignored in SCROLL/HOLD.
- Simultaneous events:
  - stop beats start and pause.
  - In IDLE, wr_en accepted together with start: the written digit is part of the message and start sees count+1.
- Display (combinational from registers):
  - IDLE, count=0: blank_hi=1, blank_lo=1.
  - IDLE, count=1: digit_hi=buf[0], blank_lo=1.
  - IDLE, count≥2: digit_hi=buf[0], digit_lo=buf[1].
  - SCROLL/HOLD: digit_hi=buf[pos], digit_lo=buf[(pos+1) mod count], both unblanked. With count=1, both show buf[0].
  - Blanked digit outputs drive 0.
- Reset values:
  - State IDLE; count=0, pos=0, tick=0.
  - wr_ready=1, busy=0, blank_hi=1, blank_lo=1, digit_hi=0, digit_lo=0.
- Reset mid-operation: an asynchronous Resetn assertion in any state returns all of the above immediately; the message is lost.

## Timing
- Write: wr_en at edge N is visible in count and on the display after edge N; wr_ready is updated the same cycle.
- Start: a pulse sampled at edge N gives busy=1 after N, pos=0, and the first step after edge N+TICK_DIV.
- Step period: exactly TICK_DIV cycles between pos changes while pause=0.
- Pause: a pause asserted for P cycles delays the next step by exactly P cycles.
- Stop: a pulse sampled at edge N gives IDLE, busy=0, and wr_ready=1 (if count < DEPTH) after N.
- No output depends combinationally on any input.

## Test plan
(TICK_DIV=4, DEPTH=8 unless noted)
- Reset: Resetn low -> count=0, blank_hi=blank_lo=1, busy=0, wr_ready=1; assertion mid-SCROLL returns the same values asynchronously.
- Load and fill: write 1,2,...,8 -> count=8, wr_ready=0; a 9th write is ignored; IDLE shows hi=1, lo=2.
- Scroll wrap: load 3,A,5, then start -> windows (3,A), (A,5), (5,3), (3,A) with exactly 4 cycles between changes.
- Pause: pause high for 3 cycles mid-period -> the next step occurs 3 cycles late; pos is unchanged during HOLD; a write during HOLD leaves count unchanged.
- Edge counts: start with count=0 -> stays IDLE, busy=0; count=1 (digit 7) -> SCROLL with hi=lo=7 and pos stays 0.
- Simultaneous events: start+stop in SCROLL -> IDLE; clear+wr_en in IDLE -> count=0; wr_en(9)+start with count=0 -> SCROLL showing hi=lo=9.
